// File: rtl/l0id_tmr_counter.sv
// Triple-redundant L0ID hold/increment register with bitwise majority vote,
// optional scrubbing and SEU detect/count monitoring.
module l0id_tmr_counter #(
   parameter int unsigned              L0ID_WIDTH   = 8,
   parameter logic [L0ID_WIDTH-1:0]    RESET_VAL    = '1,
   parameter int unsigned              ERRCNT_WIDTH = 4
) (
   input  logic                    CLK,
   input  logic                    HardResetB,
   input  logic                    L0IDReset,
   input  logic                    L0IDPreset,
   input  logic [L0ID_WIDTH-1:0]   PreL0ID,
   input  logic                    ROReadStrob,
   input  logic                    ScrubEn,
   input  logic                    ErrCntClear,
   output logic [L0ID_WIDTH-1:0]   L0ID_Local,
   output logic                    SEUDetect,
   output logic [2:0]              SEUCopyMask,
   output logic [ERRCNT_WIDTH-1:0] SEUCount,
   output logic                    SEUCountSat
);

   logic [L0ID_WIDTH-1:0]   L0IDCopy0, L0IDCopy1, L0IDCopy2;
   logic [L0ID_WIDTH-1:0]   copy_d;
   logic [L0ID_WIDTH-1:0]   vote;
   logic [2:0]              mism;
   logic                    new_evt;

   logic [2:0]              prev_mask_q, prev_mask_d;
   logic                    seu_detect_q, seu_detect_d;
   logic [2:0]              seu_mask_q, seu_mask_d;
   logic [ERRCNT_WIDTH-1:0] seu_count_q, seu_count_d;

   always_comb begin
      vote    = (L0IDCopy0 & L0IDCopy1) | (L0IDCopy0 & L0IDCopy2) | (L0IDCopy1 & L0IDCopy2);
      mism    = {(L0IDCopy2 != vote), (L0IDCopy1 != vote), (L0IDCopy0 != vote)};
      // A persistent, unchanged disagreement pattern is reported only once.
      new_evt = (|mism) && (mism != prev_mask_q);
   end

   always_comb begin
      copy_d = L0IDCopy0;
      if (L0IDReset)
         copy_d = L0IDPreset ? PreL0ID : RESET_VAL;
      else if (ROReadStrob)
         copy_d = vote + 1'b1;
      else if (ScrubEn && (|mism))
         copy_d = vote;
      else
         copy_d = vote;
   end

   always_comb begin
      prev_mask_d  = mism;
      seu_detect_d = new_evt;
      seu_mask_d   = new_evt ? mism : seu_mask_q;
      seu_count_d  = seu_count_q;
      if (ErrCntClear)
         seu_count_d = '0;
      else if (new_evt && !(&seu_count_q))
         seu_count_d = seu_count_q + 1'b1;
   end

   // Hold path rewrites each copy with itself so an unscrubbed upset persists.
   always_ff @(posedge CLK or negedge HardResetB) begin
      if (!HardResetB) begin
         L0IDCopy0 <= RESET_VAL;
         L0IDCopy1 <= RESET_VAL;
         L0IDCopy2 <= RESET_VAL;
      end else if (L0IDReset || ROReadStrob || (ScrubEn && (|mism))) begin
         L0IDCopy0 <= copy_d;
         L0IDCopy1 <= copy_d;
         L0IDCopy2 <= copy_d;
      end
   end

   always_ff @(posedge CLK or negedge HardResetB) begin
      if (!HardResetB) begin
         prev_mask_q  <= '0;
         seu_detect_q <= 1'b0;
         seu_mask_q   <= '0;
         seu_count_q  <= '0;
      end else begin
         prev_mask_q  <= prev_mask_d;
         seu_detect_q <= seu_detect_d;
         seu_mask_q   <= seu_mask_d;
         seu_count_q  <= seu_count_d;
      end
   end

   assign L0ID_Local  = vote;
   assign SEUDetect   = seu_detect_q;
   assign SEUCopyMask = seu_mask_q;
   assign SEUCount    = seu_count_q;
   assign SEUCountSat = &seu_count_q;

endmodule

// File: tb/tb_l0id_tmr_counter.sv
// Directed bench for l0id_tmr_counter: counting, preload, wrap, scrubbing and SEU monitoring.
module tb_l0id_tmr_counter;

   logic       CLK = 1'b0;
   logic       HardResetB = 1'b0;
   logic       L0IDReset = 1'b0;
   logic       L0IDPreset = 1'b0;
   logic [7:0] PreL0ID = 8'h00;
   logic       ROReadStrob = 1'b0;
   logic       ScrubEn = 1'b0;
   logic       ErrCntClear = 1'b0;
   logic [7:0] L0ID_Local;
   logic       SEUDetect;
   logic [2:0] SEUCopyMask;
   logic [3:0] SEUCount;
   logic       SEUCountSat;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned pulses;
   logic [7:0]  bad;

   l0id_tmr_counter #(.L0ID_WIDTH(8), .RESET_VAL(8'hFF), .ERRCNT_WIDTH(4)) dut (
      .CLK(CLK), .HardResetB(HardResetB), .L0IDReset(L0IDReset), .L0IDPreset(L0IDPreset),
      .PreL0ID(PreL0ID), .ROReadStrob(ROReadStrob), .ScrubEn(ScrubEn), .ErrCntClear(ErrCntClear),
      .L0ID_Local(L0ID_Local), .SEUDetect(SEUDetect), .SEUCopyMask(SEUCopyMask),
      .SEUCount(SEUCount), .SEUCountSat(SEUCountSat)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_l0id", L0ID_Local, 32'hFF);
      chk("rst_det", SEUDetect, 0);
      chk("rst_mask", SEUCopyMask, 0);
      chk("rst_cnt", SEUCount, 0);
      chk("rst_sat", SEUCountSat, 0);
      HardResetB = 1'b1;
      tick();
      chk("post_rel", L0ID_Local, 32'hFF);
      ROReadStrob = 1'b1; tick(); ROReadStrob = 1'b0;
      chk("first_strobe", L0ID_Local, 32'h00);
      chk("first_det", SEUDetect, 0);

      // Preload then back-to-back strobes
      L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'h3C; tick();
      L0IDReset = 1'b0; L0IDPreset = 1'b0;
      chk("preload_3c", L0ID_Local, 32'h3C);
      ROReadStrob = 1'b1;
      tick(); chk("b2b_3d", L0ID_Local, 32'h3D);
      tick(); chk("b2b_3e", L0ID_Local, 32'h3E);
      tick(); chk("b2b_3f", L0ID_Local, 32'h3F);
      ROReadStrob = 1'b0;

      // Wrap and reset priority
      L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'hFE; tick();
      L0IDReset = 1'b0; L0IDPreset = 1'b0;
      chk("preload_fe", L0ID_Local, 32'hFE);
      ROReadStrob = 1'b1;
      tick(); chk("wrap_ff", L0ID_Local, 32'hFF);
      tick(); chk("wrap_00", L0ID_Local, 32'h00);
      L0IDReset = 1'b1; tick();
      L0IDReset = 1'b0; ROReadStrob = 1'b0;
      chk("reset_wins", L0ID_Local, 32'hFF);

      // Scrubbed single upset on copy1
      L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'h10; tick();
      L0IDReset = 1'b0; L0IDPreset = 1'b0;
      ScrubEn = 1'b1;
      force dut.L0IDCopy1 = 8'h18;
      #1 release dut.L0IDCopy1;
      chk("scrub_vote", L0ID_Local, 32'h10);
      tick();
      chk("scrub_det", SEUDetect, 1);
      chk("scrub_mask", SEUCopyMask, 3'b010);
      chk("scrub_cnt", SEUCount, 1);
      chk("scrub_copy1", dut.L0IDCopy1, 32'h10);
      tick();
      chk("scrub_det_off", SEUDetect, 0);

      // Unscrubbed persistent upset on copy2
      ScrubEn = 1'b0;
      ErrCntClear = 1'b1; tick(); ErrCntClear = 1'b0;
      chk("clr_cnt", SEUCount, 0);
      force dut.L0IDCopy2 = 8'h11;
      #1 release dut.L0IDCopy2;
      tick();
      chk("hold_det", SEUDetect, 1);
      chk("hold_mask", SEUCopyMask, 3'b100);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         pulses += SEUDetect;
      end
      chk("hold_pulses", pulses, 0);
      chk("hold_cnt", SEUCount, 1);
      chk("hold_copy2", dut.L0IDCopy2, 32'h11);
      ROReadStrob = 1'b1; tick(); ROReadStrob = 1'b0;
      chk("hold_incr", L0ID_Local, 32'h11);
      chk("hold_cleared", dut.L0IDCopy2, 32'h11);
      tick();
      chk("hold_det_off", SEUDetect, 0);

      // Saturation: 20 distinct scrubbed upsets on top of count 1
      ScrubEn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bad = 8'h11 ^ (8'h01 << (i % 8));
         case (i % 3)
            0: begin force dut.L0IDCopy0 = bad; #1 release dut.L0IDCopy0; end
            1: begin force dut.L0IDCopy1 = bad; #1 release dut.L0IDCopy1; end
            default: begin force dut.L0IDCopy2 = bad; #1 release dut.L0IDCopy2; end
         endcase
         tick();
         tick();
      end
      chk("sat_cnt", SEUCount, 15);
      chk("sat_flag", SEUCountSat, 1);
      chk("sat_l0id", L0ID_Local, 32'h11);

      // Clear coincident with a new event
      force dut.L0IDCopy0 = 8'h13;
      #1 release dut.L0IDCopy0;
      ErrCntClear = 1'b1; tick(); ErrCntClear = 1'b0;
      chk("clr_evt_cnt", SEUCount, 0);
      chk("clr_evt_det", SEUDetect, 1);
      chk("clr_evt_mask", SEUCopyMask, 3'b001);
      chk("clr_evt_sat", SEUCountSat, 0);

      // Double upset: majority passes the wrong value, mask names the good copy
      ScrubEn = 1'b0;
      tick();
      force dut.L0IDCopy1 = 8'h55;
      force dut.L0IDCopy2 = 8'h55;
      #1;
      release dut.L0IDCopy1;
      release dut.L0IDCopy2;
      chk("dbl_vote", L0ID_Local, 32'h55);
      tick();
      chk("dbl_det", SEUDetect, 1);
      chk("dbl_mask", SEUCopyMask, 3'b001);
      chk("dbl_cnt", SEUCount, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
